// File: rtl/prioritized_dispatcher.sv
// prioritized_dispatcher
//   Registered 1-to-N dispatcher. A single valid/ready input stream is steered
//   to the highest-priority output lane whose single-entry register can take a
//   new word. Lanes are searched in the order priority_list[0], priority_list[1], ...
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-high reset
//   in_data         incoming word
//   in_valid        in_data is valid
//   in_ready        a lane can take a word this cycle (independent of in_valid)
//   out_data[i]     registered word of lane i
//   out_valid[i]    lane i holds a word
//   out_ready[i]    lane i consumer accepts the word
//   dispatch_count  number of accepted words, wraps modulo 2^count_width
//   last_lane       lane index of the most recently accepted word
module prioritized_dispatcher #(
  parameter int data_width = 8,
  parameter int number_of_inputs = 4,
  parameter int unsigned priority_list [number_of_inputs-1:0] = '{3, 1, 2, 0},
  parameter int count_width = 16,
  localparam int lane_width = (number_of_inputs > 1) ? $clog2(number_of_inputs) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [data_width-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [data_width-1:0]  out_data [number_of_inputs-1:0],
  output logic                   out_valid [number_of_inputs-1:0],
  input  logic                   out_ready [number_of_inputs-1:0],
  output logic [count_width-1:0] dispatch_count,
  output logic [lane_width-1:0]  last_lane
);

  // Pairwise comparison avoids indexing a table with 32-bit list entries.
  function automatic bit list_is_permutation();
    for (int a = 0; a < number_of_inputs; a++) begin
      if (priority_list[a] >= number_of_inputs) return 1'b0;
      for (int b = a + 1; b < number_of_inputs; b++) begin
        if (priority_list[a] == priority_list[b]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  localparam bit perm_ok = list_is_permutation();

  if (number_of_inputs < 1) begin : g_bad_count
    $fatal(1, "prioritized_dispatcher: number_of_inputs must be >= 1");
  end
  if (!perm_ok) begin : g_bad_list
    $fatal(1, "prioritized_dispatcher: priority_list must be a permutation of 0..N-1");
  end

  logic [lane_width-1:0]       order [number_of_inputs-1:0];
  logic [number_of_inputs-1:0] avail;
  logic [lane_width-1:0]       target;
  logic                        accept;

  for (genvar gi = 0; gi < number_of_inputs; gi++) begin : g_lane
    assign order[gi] = lane_width'(priority_list[gi]);
    // A full lane that is draining this cycle can be refilled in the same cycle.
    assign avail[gi] = !out_valid[gi] || out_ready[gi];
  end

  assign in_ready = |avail;
  assign accept   = in_valid && in_ready;

  // Walk the search order backwards so the smallest k with a free lane wins.
  always_comb begin
    target = '0;
    for (int k = number_of_inputs - 1; k >= 0; k--) begin
      if (avail[order[k]]) target = order[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < number_of_inputs; i++) begin
        out_valid[i] <= 1'b0;
        out_data[i]  <= '0;
      end
      dispatch_count <= '0;
      last_lane      <= '0;
    end else begin
      for (int i = 0; i < number_of_inputs; i++) begin
        if (accept && target == lane_width'(i)) begin
          out_valid[i] <= 1'b1;
          out_data[i]  <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (accept) begin
        dispatch_count <= dispatch_count + 1'b1;
        last_lane      <= target;
      end
    end
  end

endmodule

// File: tb/tb_prioritized_dispatcher.sv
module tb_prioritized_dispatcher;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data [N-1:0];
  logic          out_valid [N-1:0];
  logic          out_ready [N-1:0];
  logic [CW-1:0] dispatch_count;
  logic [LW-1:0] last_lane;

  prioritized_dispatcher #(
    .data_width(DW), .number_of_inputs(N), .count_width(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .dispatch_count(dispatch_count), .last_lane(last_lane)
  );

  always #5 clk = ~clk;

  // Reference model: lane search order written out as the spec describes it
  // (default list {3,1,2,0} visits lanes 0,2,1,3).
  int            search_order [N] = '{0, 2, 1, 3};
  bit            m_valid [N];
  logic [DW-1:0] m_data [N];
  int            m_count;
  int            m_last;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    for (int i = 0; i < N; i++) if (!m_valid[i] || out_ready[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
    end
    m_count = 0;
    m_last  = 0;
  endtask

  // Apply one clock edge worth of behaviour using the current inputs.
  task automatic model_step();
    int tgt = -1;
    foreach (search_order[k]) begin
      if (tgt < 0 && (!m_valid[search_order[k]] || out_ready[search_order[k]]))
        tgt = search_order[k];
    end
    for (int i = 0; i < N; i++) if (m_valid[i] && out_ready[i]) m_valid[i] = 1'b0;
    if (in_valid && tgt >= 0) begin
      m_valid[tgt] = 1'b1;
      m_data[tgt]  = in_data;
      m_count      = (m_count + 1) % (1 << CW);
      m_last       = tgt;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(out_valid[i]), 32'(m_valid[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(out_data[i]), 32'(m_data[i]));
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'(model_ready()));
    check({tag, "_count"}, 32'(dispatch_count), 32'(m_count));
    check({tag, "_last"}, 32'(last_lane), 32'(m_last));
  endtask

  // One cycle: inputs were set after the previous edge; compare mid-cycle,
  // advance the model, then cross the edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    $display("cyc %0t %s: in_v=%0b in_d=%02h in_rdy=%0b cnt=%0d last=%0d",
             $time, tag, in_valid, in_data, in_ready, dispatch_count, last_lane);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) out_ready[i] = r[i];
  endtask

  initial begin
    in_data  = '0;
    in_valid = 1'b0;
    set_ready('0);
    model_reset();
    #1 rst = 1'b1;
    #1 check_all("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: fill all four lanes in priority order 0,2,1,3
    for (int w = 0; w < 4; w++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(w);
      step("t1_fill");
    end
    in_valid = 1'b0;
    step("t1_full");
    check("t1_lane2", 32'(out_data[2]), 32'h A1);
    check("t1_lane1", 32'(out_data[1]), 32'h A2);
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check("t1_count", 32'(dispatch_count), 32'd4);
    check("t1_last", 32'(last_lane), 32'd3);

    // 2: blocked input, then drain+refill of lane 1
    in_valid = 1'b1;
    in_data  = 8'hB0;
    repeat (3) step("t2_blocked");
    set_ready(4'b0010);
    step("t2_refill");
    set_ready('0);
    in_valid = 1'b0;
    step("t2_after");
    check("t2_lane1_data", 32'(out_data[1]), 32'h B0);
    check("t2_lane1_valid", 32'(out_valid[1]), 32'd1);
    check("t2_count", 32'(dispatch_count), 32'd5);

    // 3: free lanes 0 and 2, keep lane 1 full
    set_ready(4'b0101);
    step("t3_drain");
    set_ready('0);
    in_valid = 1'b1;
    in_data  = 8'hC0;
    step("t3_c0");
    in_data  = 8'hC1;
    step("t3_c1");
    in_valid = 1'b0;
    step("t3_idle");
    check("t3_lane0", 32'(out_data[0]), 32'h C0);
    check("t3_lane2", 32'(out_data[2]), 32'h C1);
    check("t3_lane1", 32'(out_data[1]), 32'h B0);

    // 4: lane 3 back-pressured for 5 cycles, then drained
    repeat (5) step("t4_hold");
    check("t4_lane3_data", 32'(out_data[3]), 32'h A3);
    set_ready(4'b1000);
    step("t4_drain");
    set_ready('0);
    step("t4_empty");
    check("t4_lane3_valid", 32'(out_valid[3]), 32'd0);

    // 6: asynchronous reset with lanes 0,1,2 full, sampled before any edge
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    @(posedge clk);
    #1 rst = 1'b0;

    // 5: 17 accepts with all lanes draining; counter wraps to 1
    set_ready('1);
    in_valid = 1'b1;
    for (int w = 0; w < 17; w++) begin
      in_data = 8'($urandom);
      step("t5_wrap");
    end
    in_valid = 1'b0;
    step("t5_end");
    check("t5_count", 32'(dispatch_count), 32'd1);
    check("t5_last", 32'(last_lane), 32'd0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      set_ready(4'($urandom));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prioritized_dispatcher.md
Name: prioritized_dispatcher

Overview:
Registered 1-to-N dispatcher. It is the split-side counterpart of the team's N-to-1 prioritized arbiter.
One valid/ready input stream is steered to the highest-priority output whose single-entry output register can take a new item.
It sits upstream of a bank of parallel consumers, such as worker lanes, and shares the arbiter's priority_list convention.

Parameters:
data_width, 8, width of each data word
number_of_inputs, 4, number of output lanes N. Name kept for family consistency with the arbiter.
priority_list, {3,1,2,0}, int unsigned array [N-1:0]. Search visits index k=0 first, then k=1, and so on. The candidate lane at step k is priority_list[k]. The default gives lane search order 0,2,1,3.
count_width, 16, width of the dispatch counter

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  data_width  incoming word
in_valid  input  1  in_data is valid
in_ready  output  1  dispatcher accepts in_data this cycle
out_data  output  data_width x [N-1:0] unpacked  per-lane registered word
out_valid  output  1 x [N-1:0] unpacked  per-lane register holds a word
out_ready  input  1 x [N-1:0] unpacked  lane consumer accepts word
dispatch_count  output  count_width  number of accepted input words, wraps modulo 2^count_width
last_lane  output  $clog2(N) (min 1)  lane index of the most recent accepted word

Behaviour:
- Reset (async assert, any cycle):
  - out_valid[*]=0, out_data[*]=0, dispatch_count=0, last_lane=0.
  - In-flight words are discarded and no handshake completes while rst=1.
  - Deassertion is assumed synchronous to clk by the integrating level.
- Lane availability, combinational: avail[i] = !out_valid[i] || out_ready[i]. A full lane being drained this cycle counts as available.
- in_ready = OR of avail[*], a combinational path from out_ready. It does not depend on in_valid.
- Accept: when in_valid && in_ready, target = priority_list[k] for the smallest k with avail[priority_list[k]]=1.
- Output handshake: transfer on lane i when out_valid[i] && out_ready[i].
- Next state per lane i:
  - out_valid[i] <= (accept && target==i) || (out_valid[i] && !out_ready[i]).
  - out_data[i] <= in_data on accept to i; otherwise unchanged. Data is held stable while out_valid[i]=1 and out_ready[i]=0.
- Simultaneous drain and refill of the same lane in one cycle: out_valid[i] stays 1, out_data[i] takes the new word, and no bubble is inserted.
- Latency: an accepted word appears on out_valid/out_data of its target lane in the following cycle, so one-cycle latency.
- Throughput: one word per cycle while any lane is available.
- All lanes full and none draining: in_ready=0, and in_data/in_valid are ignored. The upstream holds in_data stable per the valid/ready rule.
- Counters on accept:
  - dispatch_count <= dispatch_count+1, wrapping from all-ones to 0.
  - last_lane <= target.
  - Both are unchanged otherwise.
- Elaboration checks:
  - priority_list must be a permutation of 0..N-1, otherwise fatal.
  - N >= 1. With N=1 the block is a single pipeline register with valid/ready.
- No combinational path from in_data to any output.

Test Plan:
1. N=4, default list, out_ready all 0. Drive words 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
   Required: they land in lanes 0,2,1,3 respectively; in_ready=0 in the cycle after the 4th accept; dispatch_count=4; last_lane=3.
2. All lanes full, out_ready=0. Hold in_valid=1 with 0xB0 for 3 cycles.
   Required: in_ready=0 and no output changes. Then raise out_ready[1]=1 for one cycle: 0xB0 goes to lane 1 with out_valid[1] still 1 (drain+refill), and dispatch_count increments by 1.
3. Lanes 0 and 2 free, lane 1 full. Send 0xC0.
   Required: 0xC0 goes to lane 0. Next word 0xC1 goes to lane 2; lane 1 contents are untouched.
4. Backpressure: a word sits in lane 3 with out_ready[3]=0 for 5 cycles.
   Required: out_data[3] and out_valid[3] are stable for all 5 cycles. When out_ready[3]=1 with no new word, out_valid[3]=0 next cycle.
5. count_width=4. Perform 17 accepted transfers with out_ready all 1.
   Required: dispatch_count=1 after the 17th accept; every word is visible on lane 0 only, since lane 0 is always available.
6. Assert rst mid-stream with 3 lanes full.
   Required: out_valid=0, out_data=0, dispatch_count=0, last_lane=0 immediately, without waiting for a clk edge. After release the first accepted word goes to lane 0.
